// File: rtl/pifo_pkg.sv
// Shared types and width helpers for the PIFO request issuer.
// The optional counters are built only when PIFO_REQ_ISSUER_STATS_EN is defined.
package pifo_pkg;

    typedef enum logic {
        OP_POP  = 1'b0,
        OP_PUSH = 1'b1
    } cmd_op_e;

    function automatic int calc_tnb(input int tree_num);
        return (tree_num > 1) ? $clog2(tree_num) : 1;
    endfunction

    function automatic int calc_dw(input int ptw, input int mtw);
        return ptw + mtw;
    endfunction

    function automatic int calc_lw(input int level);
        return (level > 1) ? $clog2(level) : 1;
    endfunction

endpackage

// File: rtl/pifo_rr_arbiter.sv
// Round-robin picker: first requesting index at or after i_ptr, wrapping to 0.
// Optional counters elsewhere are gated by PIFO_REQ_ISSUER_STATS_EN; this block has none.
module pifo_rr_arbiter
    import pifo_pkg::*;
#(
    parameter int N = 3,
    localparam int IW = calc_lw(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Two passes avoid a modulo: upper segment from the pointer first, then the wrapped part.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!o_any && i_req[j] && (IW'(j) >= i_ptr)) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!o_any && i_req[j] && (IW'(j) < i_ptr)) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/pifo_req_issuer.sv
// Spreads one push/pop command stream over LEVEL lane task-FIFO ports and merges lane pop results.
// Define PIFO_REQ_ISSUER_STATS_EN to add 32-bit push/pop/response/stall counters.
module pifo_req_issuer
    import pifo_pkg::*;
#(
    parameter int PTW             = 16,
    parameter int MTW             = 0,
    parameter int LEVEL           = 3,
    parameter int TREE_NUM        = 12,
    parameter int MAX_OUTSTANDING = 16,
    localparam int DW  = calc_dw(PTW, MTW),
    localparam int TNB = calc_tnb(TREE_NUM),
    localparam int LW  = calc_lw(LEVEL),
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_arst_n,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_op,
    input  logic [TNB-1:0]       i_cmd_tree_id,
    input  logic [DW-1:0]        i_cmd_data,
    output logic [LEVEL-1:0]     o_push,
    output logic [LEVEL-1:0]     o_pop,
    output logic [LEVEL*TNB-1:0] o_push_tree_id,
    output logic [LEVEL*TNB-1:0] o_pop_tree_id,
    output logic [LEVEL*DW-1:0]  o_push_data,
    input  logic [LEVEL-1:0]     i_task_fifo_full,
    input  logic [LEVEL-1:0]     i_is_level0_pop,
    input  logic [LEVEL*DW-1:0]  i_pop_data,
    input  logic [LEVEL*TNB-1:0] i_tree_id,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [DW-1:0]        o_rsp_data,
    output logic [TNB-1:0]       o_rsp_tree_id,
    output logic [LW-1:0]        o_rsp_lane,
    output logic [OCW-1:0]       o_outstanding,
`ifdef PIFO_REQ_ISSUER_STATS_EN
    output logic [31:0]          o_stat_push,
    output logic [31:0]          o_stat_pop,
    output logic [31:0]          o_stat_rsp,
    output logic [31:0]          o_stat_stall,
`endif
    output logic                 o_rsp_overflow
);

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [TNB-1:0] tree_id;
        logic [LW-1:0]  lane;
    } rsp_entry_t;

    function automatic logic [LW-1:0] next_lane(input logic [LW-1:0] idx);
        return (idx == LW'(LEVEL - 1)) ? '0 : idx + 1'b1;
    endfunction

    // ---------------- issue side ----------------
    logic [LEVEL-1:0]     push_q, push_d, pop_q, pop_d;
    logic [LEVEL*TNB-1:0] push_tid_q, push_tid_d, pop_tid_q, pop_tid_d;
    logic [LEVEL*DW-1:0]  push_data_q, push_data_d;
    logic [LW-1:0]        issue_ptr_q, issue_ptr_d;
    logic [LEVEL-1:0]     issue_req, issue_gnt;
    logic [LW-1:0]        issue_idx;
    logic                 issue_any;
    logic                 is_push, pop_room, cmd_ready, accept;

    // ---------------- response side ----------------
    logic [OCW-1:0]   outstanding_q, outstanding_d;
    logic             ovf_q, ovf_d;
    logic [LEVEL-1:0] hold_vld_q, hold_vld_d;
    logic [DW-1:0]    hold_data_q [LEVEL];
    logic [DW-1:0]    hold_data_d [LEVEL];
    logic [TNB-1:0]   hold_tid_q  [LEVEL];
    logic [TNB-1:0]   hold_tid_d  [LEVEL];
    rsp_entry_t       rsp_q, rsp_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [LW-1:0]    drain_ptr_q, drain_ptr_d;
    logic [LEVEL-1:0] drain_req, drain_gnt, freeing;
    logic [LW-1:0]    drain_idx, drain_sel_ptr;
    logic             drain_any, rsp_hs;

    // A lane strobed last cycle may not have raised its full flag yet, so skip it once.
    assign is_push   = (cmd_op_e'(i_cmd_op) == OP_PUSH);
    assign pop_room  = (outstanding_q < OCW'(MAX_OUTSTANDING));
    assign issue_req = ~i_task_fifo_full & ~(push_q | pop_q) & {LEVEL{is_push | pop_room}};
    assign cmd_ready = i_arst_n & issue_any;
    assign accept    = i_cmd_valid & cmd_ready;

    pifo_rr_arbiter #(.N(LEVEL)) u_issue_arb (
        .i_req (issue_req),
        .i_ptr (issue_ptr_q),
        .o_gnt (issue_gnt),
        .o_idx (issue_idx),
        .o_any (issue_any)
    );

    always_comb begin
        push_d      = '0;
        pop_d       = '0;
        push_tid_d  = push_tid_q;
        pop_tid_d   = pop_tid_q;
        push_data_d = push_data_q;
        issue_ptr_d = issue_ptr_q;
        if (accept) begin
            issue_ptr_d = next_lane(issue_idx);
            if (is_push) begin
                push_d = issue_gnt;
            end else begin
                pop_d = issue_gnt;
            end
            for (int l = 0; l < LEVEL; l++) begin
                if (issue_gnt[l]) begin
                    if (is_push) begin
                        push_tid_d[l*TNB +: TNB] = i_cmd_tree_id;
                        push_data_d[l*DW +: DW]  = i_cmd_data;
                    end else begin
                        pop_tid_d[l*TNB +: TNB] = i_cmd_tree_id;
                    end
                end
            end
        end
    end

    // The presented entry stays occupied in its holding slot until the handshake frees it.
    assign rsp_hs        = rsp_valid_q & i_rsp_ready;
    assign freeing       = rsp_hs ? (LEVEL'(1) << rsp_q.lane) : '0;
    assign drain_req     = hold_vld_q & ~freeing;
    assign drain_sel_ptr = rsp_hs ? next_lane(rsp_q.lane) : drain_ptr_q;

    pifo_rr_arbiter #(.N(LEVEL)) u_drain_arb (
        .i_req (drain_req),
        .i_ptr (drain_sel_ptr),
        .o_gnt (drain_gnt),
        .o_idx (drain_idx),
        .o_any (drain_any)
    );

    always_comb begin
        int inc;
        int dec;
        int nxt;
        hold_vld_d  = hold_vld_q & ~freeing;
        hold_data_d = hold_data_q;
        hold_tid_d  = hold_tid_q;
        ovf_d       = ovf_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        drain_ptr_d = drain_ptr_q;

        for (int l = 0; l < LEVEL; l++) begin
            if (i_is_level0_pop[l]) begin
                if (!hold_vld_q[l] || freeing[l]) begin
                    hold_vld_d[l]  = 1'b1;
                    hold_data_d[l] = i_pop_data[l*DW +: DW];
                    hold_tid_d[l]  = i_tree_id[l*TNB +: TNB];
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end

        if (rsp_hs) begin
            rsp_valid_d = 1'b0;
            drain_ptr_d = next_lane(rsp_q.lane);
        end
        if ((!rsp_valid_q || rsp_hs) && drain_any) begin
            rsp_valid_d   = 1'b1;
            rsp_d.data    = hold_data_q[drain_idx];
            rsp_d.tree_id = hold_tid_q[drain_idx];
            rsp_d.lane    = drain_idx;
        end

        // Every returned result retires one pop; more returns than pops in flight is an error.
        inc = (accept && !is_push) ? 1 : 0;
        dec = $countones(i_is_level0_pop);
        nxt = int'(outstanding_q) + inc - dec;
        if (nxt < 0) begin
            nxt   = 0;
            ovf_d = 1'b1;
        end
        outstanding_d = OCW'(nxt);
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            push_q        <= '0;
            pop_q         <= '0;
            push_tid_q    <= '0;
            pop_tid_q     <= '0;
            push_data_q   <= '0;
            issue_ptr_q   <= '0;
            outstanding_q <= '0;
            ovf_q         <= 1'b0;
            hold_vld_q    <= '0;
            rsp_q         <= '0;
            rsp_valid_q   <= 1'b0;
            drain_ptr_q   <= '0;
            for (int l = 0; l < LEVEL; l++) begin
                hold_data_q[l] <= '0;
                hold_tid_q[l]  <= '0;
            end
        end else begin
            push_q        <= push_d;
            pop_q         <= pop_d;
            push_tid_q    <= push_tid_d;
            pop_tid_q     <= pop_tid_d;
            push_data_q   <= push_data_d;
            issue_ptr_q   <= issue_ptr_d;
            outstanding_q <= outstanding_d;
            ovf_q         <= ovf_d;
            hold_vld_q    <= hold_vld_d;
            rsp_q         <= rsp_d;
            rsp_valid_q   <= rsp_valid_d;
            drain_ptr_q   <= drain_ptr_d;
            for (int l = 0; l < LEVEL; l++) begin
                hold_data_q[l] <= hold_data_d[l];
                hold_tid_q[l]  <= hold_tid_d[l];
            end
        end
    end

`ifdef PIFO_REQ_ISSUER_STATS_EN
    logic [31:0] stat_push_q, stat_push_d, stat_pop_q, stat_pop_d;
    logic [31:0] stat_rsp_q, stat_rsp_d, stat_stall_q, stat_stall_d;

    always_comb begin
        stat_push_d  = stat_push_q  + {31'd0, accept & is_push};
        stat_pop_d   = stat_pop_q   + {31'd0, accept & ~is_push};
        stat_rsp_d   = stat_rsp_q   + {31'd0, rsp_hs};
        stat_stall_d = stat_stall_q + {31'd0, i_cmd_valid & ~cmd_ready};
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            stat_push_q  <= '0;
            stat_pop_q   <= '0;
            stat_rsp_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_push_q  <= stat_push_d;
            stat_pop_q   <= stat_pop_d;
            stat_rsp_q   <= stat_rsp_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign o_stat_push  = stat_push_q;
    assign o_stat_pop   = stat_pop_q;
    assign o_stat_rsp   = stat_rsp_q;
    assign o_stat_stall = stat_stall_q;
`endif

    assign o_cmd_ready    = cmd_ready;
    assign o_push         = push_q;
    assign o_pop          = pop_q;
    assign o_push_tree_id = push_tid_q;
    assign o_pop_tree_id  = pop_tid_q;
    assign o_push_data    = push_data_q;
    assign o_rsp_valid    = rsp_valid_q;
    assign o_rsp_data     = rsp_q.data;
    assign o_rsp_tree_id  = rsp_q.tree_id;
    assign o_rsp_lane     = rsp_q.lane;
    assign o_outstanding  = outstanding_q;
    assign o_rsp_overflow = ovf_q;

endmodule

// File: tb/tb_pifo_req_issuer.sv
// Directed bench for pifo_req_issuer at default parameters (3 lanes, 16-bit data, 4-bit tree id).
module tb_pifo_req_issuer;

    localparam int DW = 16, TNB = 4, LW = 2, OCW = 5, L = 3;

    logic           clk;
    logic           arst_n;
    logic           cmd_valid, cmd_ready, cmd_op;
    logic [TNB-1:0] cmd_tree_id;
    logic [DW-1:0]  cmd_data;
    logic [L-1:0]   push, pop;
    logic [L*TNB-1:0] push_tid, pop_tid, res_tid;
    logic [L*DW-1:0]  push_data, res_data;
    logic [L-1:0]   fifo_full, l0pop;
    logic           rsp_valid, rsp_ready, rsp_ovf;
    logic [DW-1:0]  rsp_data;
    logic [TNB-1:0] rsp_tid;
    logic [LW-1:0]  rsp_lane;
    logic [OCW-1:0] outstanding;

    int n_tests = 0;
    int n_fail  = 0;

    pifo_req_issuer dut (
        .i_clk            (clk),
        .i_arst_n         (arst_n),
        .i_cmd_valid      (cmd_valid),
        .o_cmd_ready      (cmd_ready),
        .i_cmd_op         (cmd_op),
        .i_cmd_tree_id    (cmd_tree_id),
        .i_cmd_data       (cmd_data),
        .o_push           (push),
        .o_pop            (pop),
        .o_push_tree_id   (push_tid),
        .o_pop_tree_id    (pop_tid),
        .o_push_data      (push_data),
        .i_task_fifo_full (fifo_full),
        .i_is_level0_pop  (l0pop),
        .i_pop_data       (res_data),
        .i_tree_id        (res_tid),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_data       (rsp_data),
        .o_rsp_tree_id    (rsp_tid),
        .o_rsp_lane       (rsp_lane),
        .o_outstanding    (outstanding),
        .o_rsp_overflow   (rsp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] p_data [3];
        p_data = '{16'h0011, 16'h0022, 16'h0033};

        arst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_tree_id = '0; cmd_data = '0;
        fifo_full = '0; l0pop = '0; res_data = '0; res_tid = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_push", push, 0);
        chk("rst_pop", pop, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_overflow", rsp_ovf, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        arst_n = 1'b1;
        #1;
        chk("post_rst_ready", cmd_ready, 1);

        // Three pushes land on lanes 0,1,2 in order.
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_op = 1'b1; cmd_tree_id = TNB'(i); cmd_data = p_data[i];
            #1;
            chk("push_ready", cmd_ready, 1);
            tick();
            chk("push_lane", push, 3'b001 << i);
            chk("push_no_pop", pop, 0);
        end
        chk("push_data_l0", push_data[0 +: DW], 16'h0011);
        chk("push_data_l1", push_data[DW +: DW], 16'h0022);
        chk("push_data_l2", push_data[2*DW +: DW], 16'h0033);
        chk("push_tid_l1", push_tid[TNB +: TNB], 1);
        chk("push_tid_l2", push_tid[2*TNB +: TNB], 2);
        cmd_valid = 1'b0;
        tick();
        chk("push_idle", push, 0);

        // Lane 1 full: lanes alternate 0,2,0,2.
        fifo_full = 3'b010;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_op = 1'b1; cmd_tree_id = TNB'(i + 3); cmd_data = DW'(16'h0044 + i);
            #1;
            chk("full_ready", cmd_ready, 1);
            tick();
            chk("full_lane", push, (i % 2 == 0) ? 3'b001 : 3'b100);
        end
        chk("full_l1_kept", push_data[DW +: DW], 16'h0022);
        chk("full_l2_data", push_data[2*DW +: DW], 16'h0047);
        cmd_valid = 1'b0; fifo_full = '0;
        tick();

        // Sixteen pops fill the outstanding budget.
        for (int i = 0; i < 16; i++) begin
            cmd_valid = 1'b1; cmd_op = 1'b0; cmd_tree_id = TNB'(i % 12);
            #1;
            chk("pop_ready", cmd_ready, 1);
            tick();
        end
        chk("pop_last_lane", pop, 3'b001);
        chk("pop_full_cnt", outstanding, 16);
        #1;
        chk("pop_blocked", cmd_ready, 0);
        cmd_op = 1'b1; cmd_tree_id = 4'd3; cmd_data = 16'h0099;
        #1;
        chk("push_while_full", cmd_ready, 1);
        tick();
        chk("push_lane_full", push, 3'b010);
        chk("push_no_pop_full", pop, 0);
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        l0pop = 3'b100; res_data[2*DW +: DW] = 16'h0055; res_tid[2*TNB +: TNB] = 4'd5;
        tick();
        l0pop = '0;
        chk("one_result_cnt", outstanding, 15);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_tree_id = 4'd6;
        #1;
        chk("pop_reopened", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("pop_after_result", pop, 3'b100);
        chk("pop_tid_l2", pop_tid[2*TNB +: TNB], 6);
        chk("cnt_back_16", outstanding, 16);
        chk("rsp55_valid", rsp_valid, 1);
        chk("rsp55_data", rsp_data, 16'h0055);
        chk("rsp55_lane", rsp_lane, 2);
        chk("rsp55_tid", rsp_tid, 5);
        tick();
        chk("rsp55_gone", rsp_valid, 0);

        // Three simultaneous results drain in lane order.
        l0pop = 3'b111;
        res_data = {16'h000C, 16'h000B, 16'h000A};
        res_tid  = {4'd2, 4'd1, 4'd0};
        tick();
        l0pop = '0;
        chk("tri_cnt", outstanding, 13);
        chk("tri_not_yet", rsp_valid, 0);
        tick();
        chk("tri_a_valid", rsp_valid, 1);
        chk("tri_a_data", rsp_data, 16'h000A);
        chk("tri_a_lane", rsp_lane, 0);
        tick();
        chk("tri_b_data", rsp_data, 16'h000B);
        chk("tri_b_lane", rsp_lane, 1);
        chk("tri_b_tid", rsp_tid, 1);
        tick();
        chk("tri_c_data", rsp_data, 16'h000C);
        chk("tri_c_lane", rsp_lane, 2);
        tick();
        chk("tri_done", rsp_valid, 0);

        // Second result into a busy slot is dropped and flagged.
        rsp_ready = 1'b0;
        l0pop = 3'b001; res_data[0 +: DW] = 16'h1234; res_tid[0 +: TNB] = 4'd7;
        tick();
        chk("ovf_not_yet", rsp_ovf, 0);
        res_data[0 +: DW] = 16'h5678; res_tid[0 +: TNB] = 4'd8;
        tick();
        l0pop = '0;
        chk("ovf_set", rsp_ovf, 1);
        chk("ovf_rsp_valid", rsp_valid, 1);
        chk("ovf_first_kept", rsp_data, 16'h1234);
        chk("ovf_cnt", outstanding, 11);
        tick();
        chk("ovf_hold_valid", rsp_valid, 1);
        chk("ovf_hold_data", rsp_data, 16'h1234);
        chk("ovf_hold_tid", rsp_tid, 7);
        rsp_ready = 1'b1;
        tick();
        chk("ovf_only_first", rsp_valid, 0);
        tick();
        chk("ovf_no_second", rsp_valid, 0);
        chk("ovf_sticky", rsp_ovf, 1);

        // Reset with work in flight.
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_tree_id = 4'd1;
        l0pop = 3'b010; res_data[DW +: DW] = 16'h0077; res_tid[TNB +: TNB] = 4'd9;
        tick();
        l0pop = '0;
        chk("mid_pop0", pop, 3'b001);
        tick();
        cmd_valid = 1'b0;
        chk("mid_pop1", pop, 3'b010);
        chk("mid_cnt", outstanding, 12);
        chk("mid_rsp_valid", rsp_valid, 1);
        chk("mid_rsp_data", rsp_data, 16'h0077);
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_pop", pop, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_cnt", outstanding, 0);
        chk("arst_ovf", rsp_ovf, 0);
        chk("arst_ready", cmd_ready, 0);
        tick();
        arst_n = 1'b1;
        tick();
        tick();
        chk("rel_push", push, 0);
        chk("rel_pop", pop, 0);
        chk("rel_rsp_valid", rsp_valid, 0);
        chk("rel_rsp_data", rsp_data, 0);
        chk("rel_cnt", outstanding, 0);
        chk("rel_ovf", rsp_ovf, 0);
        chk("rel_ready", cmd_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
